// File: rtl/rom_burst_arbiter.sv
// Two-requester round-robin burst reader for a shared asynchronous ROM.
// Each accepted burst streams len+1 consecutive (wrapping) words through a one-deep registered output.
module rom_burst_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [3:0]       req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [3:0]       req1_len,
  output logic             req1_ready,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_last,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_last_q, rsp_last_d;
  logic             grant0_s, grant1_s;
  logic             load_s;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
      end
    end else begin
      grant1_s = 1'b0;
    end
  end

  assign load_s = (state_q == READ) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_last_d   = rsp_last_q;
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          cur_addr_d   = grant0_s ? req0_addr : req1_addr;
          remaining_d  = grant0_s ? req0_len : req1_len;
          owner_d      = grant1_s;
          last_grant_d = grant1_s;
          state_d      = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (load_s) begin
          rsp_data_d  = rom_data;
          rsp_id_d    = owner_q;
          rsp_last_d  = (remaining_q == 4'd0);
          rsp_valid_d = 1'b1;
          cur_addr_d  = cur_addr_q + AW'(1);
          remaining_d = remaining_q - 4'd1;
          state_d     = (remaining_q == 4'd0) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rom_addr   = cur_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_last   = rsp_last_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/rom_burst_arbiter.md
ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, ROM data word width in bits.
REQ-002 Parameter DEPTH, default 256, ROM word count; power of two; AW = $clog2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 burst request pending.
REQ-006 req0_addr  input  AW  requester 0 burst start address.
REQ-007 req0_len  input  4  requester 0 burst length minus one (1..16 words).
REQ-008 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_len, req1_ready: same widths and meanings as REQ-005..REQ-008, for requester 1.
REQ-010 rom_addr  output  AW  address driven to the shared asynchronous ROM.
REQ-011 rom_data  input  WIDTH  combinational ROM read data for rom_addr.
REQ-012 rsp_valid  output  1  rsp_data holds a valid beat.
REQ-013 rsp_data  output  WIDTH  registered ROM word.
REQ-014 rsp_id  output  1  requester that owns the current beat.
REQ-015 rsp_last  output  1  current beat is the final beat of its burst.
REQ-016 rsp_ready  input  1  consumer accepts the beat when rsp_valid is also high.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, READ and DRAIN.
REQ-019 In IDLE with any reqN_valid high, exactly one reqN_ready is asserted combinationally in that cycle; the request is accepted and the FSM moves to READ.
REQ-020 Arbitration is round-robin: a lone requester always wins; when both are valid, the requester not granted most recently wins.
REQ-021 On accept: cur_addr <= reqN_addr; remaining <= reqN_len; owner id <= N; last_grant <= N.
REQ-022 reqN_ready is 0 outside IDLE and 0 for the losing requester.
REQ-023 rom_addr equals the registered cur_addr in all states, with no combinational path from the request inputs.
REQ-024 In READ, a beat loads when (!rsp_valid || rsp_ready): rsp_data <= rom_data, rsp_id <= owner, rsp_last <= (remaining == 0), rsp_valid <= 1.
REQ-025 On each load, cur_addr increments modulo DEPTH (DEPTH-1 wraps to 0) and remaining decrements.
REQ-026 When the loaded beat is the last, the FSM moves to DRAIN; cur_addr still increments.
REQ-027 In READ with rsp_valid && !rsp_ready, no load occurs and rsp_data, rsp_id, rsp_last, cur_addr and remaining hold.
REQ-028 In DRAIN, when rsp_ready is high: rsp_valid <= 0, rsp_last <= 0, FSM moves to IDLE; otherwise all outputs hold.
REQ-029 Latency: with request accepted in cycle T and rsp_ready held high, beat k (k = 0..len) is valid in cycle T+2+k.
REQ-030 A burst of length L+1 produces exactly L+1 beats, in ascending wrapped address order, each accepted exactly once.
REQ-031 The earliest next request acceptance is in the cycle after DRAIN exits; there is no overlap of bursts.
REQ-032 Requests are not queued: reqN_valid must be held until reqN_ready; a request dropped before acceptance is ignored.

Reset
REQ-033 While rst is high at a rising edge: FSM <= IDLE; rsp_valid, rsp_last, rsp_id <= 0; rsp_data <= 0; rom_addr (cur_addr) <= 0; remaining <= 0; last_grant <= 1, so requester 0 wins the first tie.
REQ-034 Reset mid-burst abandons the burst with no further beats.
REQ-035 reqN_ready is 0 in any cycle in which rst is high.

Verification
REQ-036 ROM word[a] = a ^ 8'h5A; req0 addr=0x10 len=3; rsp_ready=1 -> beats 0x4A,0x4B,0x48,0x49 in cycles T+2..T+5; rsp_id=0; rsp_last only on 0x49.
REQ-037 req0 and req1 valid together after reset -> req0 granted first; next tie -> req1; next tie -> req0.
REQ-038 req1 addr=0xFE len=3 -> rom_addr sequence 0xFE,0xFF,0x00,0x01; four beats; rsp_id=1.
REQ-039 rsp_ready toggled 1,0,0,1 during a 4-beat burst -> no beat lost or duplicated; rsp_data stable while stalled; busy high until DRAIN handshake.
REQ-040 rst pulsed for 1 cycle during beat 2 of a 16-beat burst -> next cycle rsp_valid=0, busy=0, rom_addr=0; a new req0 is accepted immediately and completes normally.
